// File: rtl/ram_3d_pkg.sv
// ram_3d_pkg
// Shared definitions for the ram_3d stream sequencer:
//   state_t     - sequencer FSM states
//   FIFO_DEPTH  - depth of the drain-side output FIFO
//   len_w()     - width of length/word counters for a given bank geometry
package ram_3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  localparam int FIFO_DEPTH = 3;

  // Wide enough to hold the full capacity RAM_NUM*2**ADDRESS (inclusive).
  function automatic int len_w(input int ram_num, input int address);
    return $clog2(ram_num * (2 ** address)) + 1;
  endfunction

endpackage

// File: rtl/ram_3d_skid_fifo.sv
// ram_3d_skid_fifo
// Small FIFO_DEPTH-entry synchronous FIFO buffering port-B read data.
// Ports:
//   clk, rst      clock, synchronous active-low reset (empties the FIFO)
//   i_push/i_data write one word (caller guarantees space)
//   i_pop         remove head word (ignored when empty)
//   o_data        head word, o_valid = not empty, o_occ = occupancy
module ram_3d_skid_fifo
  import ram_3d_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_occ;
  logic             w_push;
  logic             w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

  assign w_pop  = i_pop && (r_occ != '0);
  assign w_push = i_push && ((r_occ != 2'(FIFO_DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/ram_3d_stream_ctrl.sv
// ram_3d_stream_ctrl
// Writes a valid/ready word stream round-robin across RAM_NUM banks of a
// ram_3d instance (port A), then on command reads the words back in order
// (port B) and emits them as a backpressured stream.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   fill_start, len          start a fill of len words (IDLE only)
//   drain_start              start draining the stored words (HOLD only)
//   fill_done, drain_done    one-cycle completion pulses
//   busy                     not IDLE
//   s_valid/s_ready/s_data   input stream
//   m_valid/m_ready/m_data   output stream
//   ram_*                    all enables/addresses/data of the ram_3d banks
module ram_3d_stream_ctrl
  import ram_3d_pkg::*;
#(
  parameter  int RAM_NUM = 3,
  parameter  int WIDTH   = 16,
  parameter  int ADDRESS = 12,
  localparam int LEN_W   = len_w(RAM_NUM, ADDRESS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_start,
  input  logic               drain_start,
  input  logic [LEN_W-1:0]   len,
  output logic               fill_done,
  output logic               drain_done,
  output logic               busy,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [RAM_NUM-1:0] ram_ena,
  output logic [RAM_NUM-1:0] ram_wea,
  output logic [RAM_NUM-1:0] ram_enb,
  output logic [RAM_NUM-1:0] ram_web,
  output logic [ADDRESS-1:0] ram_addra [0:RAM_NUM-1],
  output logic [ADDRESS-1:0] ram_addrb [0:RAM_NUM-1],
  output logic [WIDTH-1:0]   ram_dina  [0:RAM_NUM-1],
  output logic [WIDTH-1:0]   ram_dinb  [0:RAM_NUM-1],
  input  logic [WIDTH-1:0]   ram_doutb [0:RAM_NUM-1]
);

  localparam int BANK_W = (RAM_NUM > 1) ? $clog2(RAM_NUM) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(RAM_NUM - 1);

  state_t              r_state;
  state_t              w_next;

  logic [LEN_W-1:0]    r_len;
  logic [BANK_W-1:0]   r_wr_bank;
  logic [ADDRESS-1:0]  r_wr_addr;
  logic [LEN_W-1:0]    r_wr_cnt;
  logic [BANK_W-1:0]   r_rd_bank;
  logic [ADDRESS-1:0]  r_rd_addr;
  logic [LEN_W-1:0]    r_rd_cnt;
  logic [LEN_W-1:0]    r_pop_cnt;
  logic                r_rd_v;
  logic [BANK_W-1:0]   r_rd_bank_d1;
  logic                r_zero_fill_done;

  logic                w_wr_fire;
  logic                w_wr_last;
  logic                w_rd_issue;
  logic                w_pop;
  logic                w_drain_last;
  logic [1:0]          w_occ;
  logic [2:0]          w_credit;
  logic                w_fifo_valid;
  logic [WIDTH-1:0]    w_fifo_data;

  // Datapath decodes
  assign w_wr_fire = (r_state == ST_FILL) && s_valid;
  assign w_wr_last = w_wr_fire && (r_wr_cnt == r_len - LEN_W'(1));

  // Buffered words plus the read in flight must leave room for a new read,
  // otherwise its data could arrive at a full FIFO.
  assign w_credit   = {1'b0, w_occ} + {2'b00, r_rd_v};
  assign w_rd_issue = (r_state == ST_DRAIN) && (r_rd_cnt != r_len)
                      && (w_credit < 3'(FIFO_DEPTH));

  assign w_pop        = w_fifo_valid && m_ready;
  assign w_drain_last = (r_state == ST_DRAIN)
                        && ((r_len == '0) || (w_pop && (r_pop_cnt == r_len - LEN_W'(1))));

  ram_3d_skid_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_rd_v),
    .i_data (ram_doutb[r_rd_bank_d1]),
    .i_pop  (w_pop),
    .o_data (w_fifo_data),
    .o_valid(w_fifo_valid),
    .o_occ  (w_occ)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (fill_start) w_next = (len == '0) ? ST_HOLD : ST_FILL;
      ST_FILL:  if (w_wr_last) w_next = ST_HOLD;
      ST_HOLD:  if (drain_start) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Counters: bank counter wraps at RAM_NUM-1 and carries into the address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len            <= '0;
      r_wr_bank        <= '0;
      r_wr_addr        <= '0;
      r_wr_cnt         <= '0;
      r_rd_bank        <= '0;
      r_rd_addr        <= '0;
      r_rd_cnt         <= '0;
      r_pop_cnt        <= '0;
      r_rd_v           <= 1'b0;
      r_rd_bank_d1     <= '0;
      r_zero_fill_done <= 1'b0;
    end else begin
      r_rd_v           <= w_rd_issue;
      r_rd_bank_d1     <= r_rd_bank;
      r_zero_fill_done <= (r_state == ST_IDLE) && fill_start && (len == '0);
      case (r_state)
        ST_IDLE: begin
          if (fill_start) begin
            r_len     <= len;
            r_wr_bank <= '0;
            r_wr_addr <= '0;
            r_wr_cnt  <= '0;
          end
        end
        ST_FILL: begin
          if (w_wr_fire) begin
            r_wr_cnt <= r_wr_cnt + LEN_W'(1);
            if (r_wr_bank == LAST_BANK) begin
              r_wr_bank <= '0;
              r_wr_addr <= r_wr_addr + ADDRESS'(1);
            end else begin
              r_wr_bank <= r_wr_bank + BANK_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (drain_start) begin
            r_rd_bank <= '0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_pop_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_rd_issue) begin
            r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            if (r_rd_bank == LAST_BANK) begin
              r_rd_bank <= '0;
              r_rd_addr <= r_rd_addr + ADDRESS'(1);
            end else begin
              r_rd_bank <= r_rd_bank + BANK_W'(1);
            end
          end
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy       = (r_state != ST_IDLE);
    s_ready    = (r_state == ST_FILL);
    fill_done  = w_wr_last || r_zero_fill_done;
    drain_done = w_drain_last;
    m_valid    = w_fifo_valid;
    m_data     = w_fifo_data;
    ram_ena    = '0;
    ram_wea    = '0;
    ram_enb    = '0;
    ram_web    = '0;
    for (int unsigned b = 0; b < RAM_NUM; b++) begin
      ram_addra[b] = '0;
      ram_addrb[b] = '0;
      ram_dina[b]  = '0;
      ram_dinb[b]  = '0;
      if (w_wr_fire && (r_wr_bank == BANK_W'(b))) begin
        ram_ena[b]   = 1'b1;
        ram_wea[b]   = 1'b1;
        ram_addra[b] = r_wr_addr;
        ram_dina[b]  = s_data;
      end
      if (w_rd_issue && (r_rd_bank == BANK_W'(b))) begin
        ram_enb[b]   = 1'b1;
        ram_addrb[b] = r_rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_3d_stream_ctrl.sv
module tb_ram_3d_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_start;
  logic        drain_start;
  logic [14:0] len;
  logic        fill_done;
  logic        drain_done;
  logic        busy;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [2:0]  ram_ena;
  logic [2:0]  ram_wea;
  logic [2:0]  ram_enb;
  logic [2:0]  ram_web;
  logic [11:0] ram_addra [0:2];
  logic [11:0] ram_addrb [0:2];
  logic [15:0] ram_dina  [0:2];
  logic [15:0] ram_dinb  [0:2];
  logic [15:0] ram_doutb [0:2];

  int checks   = 0;
  int failures = 0;

  ram_3d_stream_ctrl #(
    .RAM_NUM(3),
    .WIDTH  (16),
    .ADDRESS(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .drain_start(drain_start),
    .len        (len),
    .fill_done  (fill_done),
    .drain_done (drain_done),
    .busy       (busy),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .ram_ena    (ram_ena),
    .ram_wea    (ram_wea),
    .ram_enb    (ram_enb),
    .ram_web    (ram_web),
    .ram_addra  (ram_addra),
    .ram_addrb  (ram_addrb),
    .ram_dina   (ram_dina),
    .ram_dinb   (ram_dinb),
    .ram_doutb  (ram_doutb)
  );

  always #5 clk = ~clk;

  // Behavioural ram_3d: per-bank memory, registered port-B read.
  logic [15:0] mem [0:2][0:4095];
  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (ram_ena[b] && ram_wea[b]) mem[b][ram_addra[b]] <= ram_dina[b];
      if (ram_enb[b]) ram_doutb[b] <= mem[b][ram_addrb[b]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fill n words base, base+1, ...; checks every port-A write in flight.
  task automatic do_fill(input int n, input logic [15:0] base);
    fill_start = 1'b1;
    len        = 15'(n);
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = base + 16'(k);
      #1;
      chk("fill_s_ready", 32'(s_ready), 1);
      chk("fill_ena", 32'(ram_ena), 32'(1) << (k % 3));
      chk("fill_wea", 32'(ram_wea), 32'(1) << (k % 3));
      chk("fill_addra", 32'(ram_addra[k % 3]), k / 3);
      chk("fill_dina", 32'(ram_dina[k % 3]), 32'(base) + k);
      chk("fill_done", 32'(fill_done), (k == n - 1) ? 1 : 0);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("hold_busy", 32'(busy), 1);
    chk("hold_s_ready", 32'(s_ready), 0);
    chk("hold_ena", 32'(ram_ena), 0);
  endtask

  initial begin
    int npop;
    int nissue;
    bit done;

    rst         = 1'b0;
    fill_start  = 1'b0;
    drain_start = 1'b0;
    len         = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    m_ready     = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_drain_done", 32'(drain_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'({ram_ena, ram_wea, ram_enb, ram_web}), 0);
    for (int b = 0; b < 3; b++) begin
      chk("rst_addra", 32'(ram_addra[b]), 0);
      chk("rst_addrb", 32'(ram_addrb[b]), 0);
      chk("rst_dina", 32'(ram_dina[b]), 0);
      chk("rst_dinb", 32'(ram_dinb[b]), 0);
    end
    rst = 1'b1;
    tick();
    chk("rel_busy", 32'(busy), 0);

    // Fill 7 words 1..7, round-robin placement
    do_fill(7, 16'h0001);
    chk("mem_b0a0", 32'(mem[0][0]), 1);
    chk("mem_b0a1", 32'(mem[0][1]), 4);
    chk("mem_b0a2", 32'(mem[0][2]), 7);
    chk("mem_b1a0", 32'(mem[1][0]), 2);
    chk("mem_b1a1", 32'(mem[1][1]), 5);
    chk("mem_b2a0", 32'(mem[2][0]), 3);
    chk("mem_b2a1", 32'(mem[2][1]), 6);

    // Drain with m_ready high: data in cycles 3..9, drain_done in cycle 9
    m_ready     = 1'b1;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("dr_m_valid", 32'(m_valid), (c >= 3) ? 1 : 0);
      if (c >= 3) chk("dr_m_data", 32'(m_data), c - 2);
      chk("dr_done", 32'(drain_done), (c == 9) ? 1 : 0);
      chk("dr_enb", 32'(ram_enb), (c <= 7) ? (32'(1) << ((c - 1) % 3)) : 0);
      chk("dr_web", 32'(ram_web), 0);
      if (c <= 7) chk("dr_addrb", 32'(ram_addrb[(c - 1) % 3]), (c - 1) / 3);
      tick();
    end
    chk("dr_idle", 32'(busy), 0);

    // Drain with m_ready pattern 1,0,0,... : order, hold stability, bound of 3
    do_fill(7, 16'h0011);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    npop   = 0;
    nissue = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      m_ready = (c % 3 == 0);
      #1;
      if (ram_enb != '0) nissue++;
      chk("tog_buffered", 32'(nissue - npop <= 3), 1);
      if (m_valid) chk("tog_data", 32'(m_data), 32'h11 + npop);
      if (m_valid && m_ready) begin
        chk("tog_done", 32'(drain_done), (npop == 6) ? 1 : 0);
        npop++;
        if (drain_done) done = 1'b1;
      end
      tick();
    end
    chk("tog_finished", 32'(done), 1);
    chk("tog_pops", npop, 7);
    chk("tog_reads", nissue, 7);
    chk("tog_idle", 32'(busy), 0);

    // Zero-length fill and drain
    m_ready    = 1'b1;
    fill_start = 1'b1;
    len        = '0;
    tick();
    fill_start = 1'b0;
    chk("z_fill_done", 32'(fill_done), 1);
    chk("z_busy", 32'(busy), 1);
    chk("z_s_ready", 32'(s_ready), 0);
    tick();
    chk("z_fill_done_clr", 32'(fill_done), 0);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("z_drain_done", 32'(drain_done), 1);
    chk("z_m_valid", 32'(m_valid), 0);
    chk("z_enb", 32'(ram_enb), 0);
    tick();
    chk("z_idle", 32'(busy), 0);
    chk("z_m_valid2", 32'(m_valid), 0);

    // Reset after 2 of 4 drained words, then a 1-word 0xBEEF round trip
    do_fill(4, 16'h0021);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    chk("rm_w0", 32'(m_data), 32'h21);
    tick();
    chk("rm_w1", 32'(m_data), 32'h22);
    tick();
    rst = 1'b0;
    tick();
    chk("rm_busy", 32'(busy), 0);
    chk("rm_m_valid", 32'(m_valid), 0);
    chk("rm_enb", 32'(ram_enb), 0);
    chk("rm_drain_done", 32'(drain_done), 0);
    rst = 1'b1;
    tick();
    chk("rm_rel_busy", 32'(busy), 0);
    chk("rm_rel_m_valid", 32'(m_valid), 0);
    do_fill(1, 16'hBEEF);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    npop = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (m_valid && m_ready) begin
        chk("bf_data", 32'(m_data), 32'hBEEF);
        npop++;
      end
      if (drain_done) done = 1'b1;
      tick();
    end
    chk("bf_finished", 32'(done), 1);
    chk("bf_pops", npop, 1);
    chk("bf_idle", 32'(busy), 0);
    chk("bf_m_valid", 32'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
